// File: rtl/edge_pkg.sv
// Shared definitions for the edge event collector: FSM state codes and lane index width helper.
package edge_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_SCAN = 2'd1;
    localparam state_t ST_EMIT = 2'd2;

    // Lane index width, never narrower than one bit.
    function automatic int unsigned lane_w(input int unsigned lanes);
        return (lanes > 1) ? $clog2(lanes) : 1;
    endfunction

endpackage

// File: rtl/edge_lane_counter.sv
// Per-lane event counter with sticky overflow and handshake subtraction.
// EDGE_CNT_SAT_EN defined: saturate at all-ones; undefined: wrap modulo 2^CNT_W.
module edge_lane_counter #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             inc,
    input  logic             sub_en,
    input  logic [CNT_W-1:0] sub_val,
    output logic [CNT_W-1:0] count,
    output logic             ovf
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] base_c;
    logic [CNT_W-1:0] count_d;
    logic             ovf_d;

    // Subtract the accepted snapshot first, then add this cycle's event.
    always_comb begin
        base_c  = sub_en ? (count - sub_val) : count;
        count_d = base_c;
        ovf_d   = sub_en ? 1'b0 : ovf;
        if (inc) begin
            if (!sub_en && (count == CNT_MAX)) begin
                ovf_d = 1'b1;
            end
`ifdef EDGE_CNT_SAT_EN
            count_d = (base_c == CNT_MAX) ? CNT_MAX : (base_c + CNT_W'(1));
`else
            count_d = base_c + CNT_W'(1);
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            count <= '0;
            ovf   <= 1'b0;
        end else begin
            count <= count_d;
            ovf   <= ovf_d;
        end
    end

endmodule

// File: rtl/edge_event_collector.sv
// Counts anyedge pulses per lane and, on flush, reads out one (lane, count) record per
// non-zero lane over a valid/ready port. Counter mode selected by EDGE_CNT_SAT_EN.
module edge_event_collector
    import edge_pkg::*;
#(
    parameter int unsigned LANES = 8,
    parameter int unsigned CNT_W = 8
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic [LANES-1:0]          anyedge,
    input  logic                      flush,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [lane_w(LANES)-1:0]  out_lane,
    output logic [CNT_W-1:0]          out_count,
    output logic [LANES-1:0]          overflow,
    output logic                      busy
);

    localparam int unsigned LANE_W = lane_w(LANES);
    localparam logic [LANE_W-1:0] LAST_IDX = LANE_W'(LANES - 1);

    state_t              state;
    state_t              state_d;
    logic [LANE_W-1:0]   idx;
    logic [LANE_W-1:0]   idx_d;
    logic                out_valid_d;
    logic [LANE_W-1:0]   out_lane_d;
    logic [CNT_W-1:0]    out_count_d;
    logic                hs_c;
    logic [LANES-1:0]    sub_en_c;
    logic [CNT_W-1:0]    lane_count [LANES];

    assign hs_c = out_valid & out_ready;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        assign sub_en_c[g] = hs_c && (out_lane == LANE_W'(g));

        edge_lane_counter #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .clk     (clk),
            .resetn  (resetn),
            .inc     (anyedge[g]),
            .sub_en  (sub_en_c[g]),
            .sub_val (out_count),
            .count   (lane_count[g]),
            .ovf     (overflow[g])
        );
    end

    // Scan lanes in order; a non-empty lane is snapshotted and held until accepted.
    always_comb begin
        state_d     = state;
        idx_d       = idx;
        out_valid_d = out_valid;
        out_lane_d  = out_lane;
        out_count_d = out_count;
        case (state)
            ST_IDLE: begin
                if (flush) begin
                    state_d = ST_SCAN;
                    idx_d   = '0;
                end
            end
            ST_SCAN: begin
                if (lane_count[idx] != '0) begin
                    out_lane_d  = idx;
                    out_count_d = lane_count[idx];
                    out_valid_d = 1'b1;
                    state_d     = ST_EMIT;
                end else if (idx == LAST_IDX) begin
                    state_d = ST_IDLE;
                end else begin
                    idx_d = idx + LANE_W'(1);
                end
            end
            ST_EMIT: begin
                if (hs_c) begin
                    out_valid_d = 1'b0;
                    if (idx == LAST_IDX) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_SCAN;
                        idx_d   = idx + LANE_W'(1);
                    end
                end
            end
            default: begin
                state_d     = ST_IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= ST_IDLE;
            idx       <= '0;
            out_valid <= 1'b0;
            out_lane  <= '0;
            out_count <= '0;
            busy      <= 1'b0;
        end else begin
            state     <= state_d;
            idx       <= idx_d;
            out_valid <= out_valid_d;
            out_lane  <= out_lane_d;
            out_count <= out_count_d;
            busy      <= (state_d != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_edge_event_collector.sv
// Self-checking bench for edge_event_collector (LANES=8, CNT_W=4); honours EDGE_CNT_SAT_EN.
module tb_edge_event_collector;

    localparam int LANES = 8;
    localparam int CNT_W = 4;
    localparam int CMAX  = 15;
    localparam int MOD   = 16;

    logic             clk = 1'b0;
    logic             resetn;
    logic [LANES-1:0] anyedge;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [2:0]       out_lane;
    logic [CNT_W-1:0] out_count;
    logic [LANES-1:0] overflow;
    logic             busy;

    always #5 clk = ~clk;

    edge_event_collector #(.LANES(LANES), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .anyedge   (anyedge),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_lane  (out_lane),
        .out_count (out_count),
        .overflow  (overflow),
        .busy      (busy)
    );

    int npass = 0;
    int ntot  = 0;

    // Reference model: true per-lane counts plus readout pass position (-1 = idle).
    int               mcnt [LANES];
    logic [LANES-1:0] movf;
    int               mpos;
    bit               mvalid;
    int               mlane;
    int               mcount;

    typedef struct {
        logic [7:0] ae;
        logic       fl;
        logic       ev;
        logic       eb;
        int         el;
        int         ec;
    } vec_t;

    vec_t tv [15];

    task automatic chk(input string name, input int act, input int exp);
        ntot++;
        if (act == exp) npass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    task automatic model_edge(input logic [7:0] ae, input logic fl, input logic rdy, input logic rstn);
        int old [LANES];
        bit hs;
        bit hit;
        int c;
        if (!rstn) begin
            for (int i = 0; i < LANES; i++) mcnt[i] = 0;
            movf = '0; mpos = -1; mvalid = 0; mlane = 0; mcount = 0;
            return;
        end
        old = mcnt;
        hs  = mvalid && rdy;
        for (int i = 0; i < LANES; i++) begin
            c   = old[i];
            hit = hs && (mlane == i);
            if (hit) begin
                c = (c - mcount + MOD) % MOD;
                movf[i] = 1'b0;
            end
            if (ae[i]) begin
                if (!hit && old[i] == CMAX) movf[i] = 1'b1;
`ifdef EDGE_CNT_SAT_EN
                c = (c >= CMAX) ? CMAX : c + 1;
`else
                c = (c + 1) % MOD;
`endif
            end
            mcnt[i] = c;
        end
        if (mpos < 0) begin
            if (fl) mpos = 0;
        end else if (mvalid) begin
            if (hs) begin
                mvalid = 0;
                mpos   = (mlane == LANES - 1) ? -1 : mlane + 1;
            end
        end else if (old[mpos] != 0) begin
            mvalid = 1; mlane = mpos; mcount = old[mpos];
        end else begin
            mpos = (mpos == LANES - 1) ? -1 : mpos + 1;
        end
    endtask

    task automatic cmp_model();
        chk("m_valid", int'(out_valid), int'(mvalid));
        chk("m_busy", int'(busy), (mpos >= 0) ? 1 : 0);
        chk("m_ovf", int'(overflow), int'(movf));
        if (mvalid) begin
            chk("m_lane", int'(out_lane), mlane);
            chk("m_count", int'(out_count), mcount);
        end
    endtask

    task automatic step(input logic [7:0] ae, input logic fl, input logic rdy, input logic rstn);
        @(negedge clk);
        anyedge = ae; flush = fl; out_ready = rdy; resetn = rstn;
        @(posedge clk);
        model_edge(ae, fl, rdy, rstn);
        #1 cmp_model();
    endtask

    // Flush, wait for a single record, check it, accept it and let the pass finish.
    task automatic readout_one(input string name, input int el, input int ec);
        bit seen = 0;
        step(8'h00, 1'b1, 1'b0, 1'b1);
        for (int k = 0; k < 12 && !seen; k++) begin
            step(8'h00, 1'b0, 1'b0, 1'b1);
            seen = out_valid;
        end
        chk({name, "_seen"}, int'(seen), 1);
        if (seen) begin
            chk({name, "_lane"}, int'(out_lane), el);
            chk({name, "_count"}, int'(out_count), ec);
            step(8'h00, 1'b0, 1'b1, 1'b1);
        end
        for (int k = 0; k < 12 && busy; k++) step(8'h00, 1'b0, 1'b1, 1'b1);
        chk({name, "_idle"}, int'(busy), 0);
    endtask

    initial begin
        int nrec;
        bit seen;
        resetn = 1'b0; anyedge = '0; flush = 1'b0; out_ready = 1'b0;
        model_edge(8'h00, 1'b0, 1'b0, 1'b0);

        // Test 1: reset mid-traffic, then an empty pass.
        for (int k = 0; k < 20; k++) step(8'($urandom), (k == 8), 1'($urandom), 1'b1);
        step(8'hFF, 1'b0, 1'b0, 1'b0);
        step(8'hFF, 1'b0, 1'b0, 1'b0);
        chk("t1_valid", int'(out_valid), 0);
        chk("t1_busy", int'(busy), 0);
        chk("t1_ovf", int'(overflow), 0);
        chk("t1_lane", int'(out_lane), 0);
        chk("t1_count", int'(out_count), 0);
        step(8'h00, 1'b1, 1'b1, 1'b1);
        nrec = 0;
        for (int k = 0; k < 8; k++) begin
            step(8'h00, 1'b0, 1'b1, 1'b1);
            nrec += int'(out_valid);
        end
        chk("t1_records", nrec, 0);
        chk("t1_idle", int'(busy), 0);

        // Test 2: table of per-cycle vectors, out_ready held high.
        tv[0]  = '{8'h01, 1'b0, 1'b0, 1'b0, 0, 0};
        tv[1]  = '{8'h01, 1'b0, 1'b0, 1'b0, 0, 0};
        tv[2]  = '{8'h01, 1'b0, 1'b0, 1'b0, 0, 0};
        tv[3]  = '{8'h40, 1'b0, 1'b0, 1'b0, 0, 0};
        tv[4]  = '{8'h00, 1'b1, 1'b0, 1'b1, 0, 0};
        tv[5]  = '{8'h00, 1'b0, 1'b1, 1'b1, 0, 3};
        for (int k = 6; k < 12; k++) tv[k] = '{8'h00, 1'b0, 1'b0, 1'b1, 0, 0};
        tv[12] = '{8'h00, 1'b0, 1'b1, 1'b1, 6, 1};
        tv[13] = '{8'h00, 1'b0, 1'b0, 1'b1, 0, 0};
        tv[14] = '{8'h00, 1'b0, 1'b0, 1'b0, 0, 0};
        for (int k = 0; k < 15; k++) begin
            step(tv[k].ae, tv[k].fl, 1'b1, 1'b1);
            chk($sformatf("t2_valid[%0d]", k), int'(out_valid), int'(tv[k].ev));
            chk($sformatf("t2_busy[%0d]", k), int'(busy), int'(tv[k].eb));
            if (tv[k].ev) begin
                chk($sformatf("t2_lane[%0d]", k), int'(out_lane), tv[k].el);
                chk($sformatf("t2_count[%0d]", k), int'(out_count), tv[k].ec);
            end
        end

        // Test 3: backpressure while lane 0 keeps counting.
        step(8'h01, 1'b0, 1'b0, 1'b1);
        step(8'h01, 1'b0, 1'b0, 1'b1);
        step(8'h00, 1'b1, 1'b0, 1'b1);
        step(8'h00, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 5; k++) begin
            step((k == 0 || k == 2) ? 8'h01 : 8'h00, 1'b0, 1'b0, 1'b1);
            chk("t3_valid", int'(out_valid), 1);
            chk("t3_lane", int'(out_lane), 0);
            chk("t3_count", int'(out_count), 2);
        end
        step(8'h00, 1'b0, 1'b1, 1'b1);
        for (int k = 0; k < 12 && busy; k++) step(8'h00, 1'b0, 1'b1, 1'b1);
        readout_one("t3_rec", 0, 2);

        // Test 4: handshake and increment on lane 3 in the same cycle.
        for (int k = 0; k < 4; k++) step(8'h08, 1'b0, 1'b0, 1'b1);
        step(8'h00, 1'b1, 1'b0, 1'b1);
        seen = 0;
        for (int k = 0; k < 10 && !seen; k++) begin
            step(8'h00, 1'b0, 1'b0, 1'b1);
            seen = out_valid;
        end
        chk("t4_seen", int'(seen), 1);
        chk("t4_lane", int'(out_lane), 3);
        chk("t4_count", int'(out_count), 4);
        step(8'h08, 1'b0, 1'b1, 1'b1);
        for (int k = 0; k < 12 && busy; k++) step(8'h00, 1'b0, 1'b1, 1'b1);
        readout_one("t4_rec", 3, 1);

        // Test 5: 17 pulses on lane 2 with a 4-bit counter.
        for (int k = 0; k < 17; k++) step(8'h04, 1'b0, 1'b0, 1'b1);
        chk("t5_ovf_set", int'(overflow[2]), 1);
`ifdef EDGE_CNT_SAT_EN
        readout_one("t5_rec", 2, 15);
`else
        readout_one("t5_rec", 2, 1);
`endif
        chk("t5_ovf_clr", int'(overflow[2]), 0);

        // Test 6a: flush during a pass is ignored, giving a single pass.
        step(8'h21, 1'b0, 1'b0, 1'b1);
        step(8'h00, 1'b1, 1'b1, 1'b1);
        nrec = 0;
        for (int k = 0; k < 20 && busy; k++) begin
            step(8'h00, 1'b1, 1'b1, 1'b1);
            nrec += int'(out_valid);
        end
        chk("t6_records", nrec, 2);
        for (int k = 0; k < 3; k++) begin
            step(8'h00, 1'b0, 1'b1, 1'b1);
            chk("t6_idle", int'(busy), 0);
        end

        // Test 6b: reset while a record is pending drops it.
        step(8'h01, 1'b0, 1'b0, 1'b1);
        step(8'h00, 1'b1, 1'b0, 1'b1);
        step(8'h00, 1'b0, 1'b0, 1'b1);
        chk("t6_emit", int'(out_valid), 1);
        step(8'h00, 1'b0, 1'b0, 1'b0);
        chk("t6_rst_valid", int'(out_valid), 0);
        chk("t6_rst_busy", int'(busy), 0);
        nrec = 0;
        for (int k = 0; k < 10; k++) begin
            step(8'h00, 1'b0, 1'b1, 1'b1);
            nrec += int'(out_valid);
        end
        chk("t6_no_late_rec", nrec, 0);

        // Randomised traffic against the reference model.
        for (int k = 0; k < 3000; k++) begin
            step(8'($urandom), ($urandom_range(0, 19) == 0), 1'($urandom),
                 ($urandom_range(0, 199) != 0));
        end

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
